// File: rtl/compare_seq.sv
// Sequential magnitude comparator: WIDTH-bit operands examined CHUNK bits per cycle, MSB-first,
// with early exit on the first differing chunk. Define SIGNED_EN for two's-complement operands.
module compare_seq #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start,
  input  logic [WIDTH-1:0]                   a,
  input  logic [WIDTH-1:0]                   b,
  output logic                               busy,
  output logic                               done,
  output logic                               more,
  output logic                               less,
  output logic                               equal,
  output logic [$clog2(WIDTH/CHUNK+1)-1:0]   cycles
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = $clog2(NCHUNK + 1);

  generate
    if ((CHUNK < 1) || (WIDTH < CHUNK) || ((WIDTH % CHUNK) != 0)) begin : g_bad_cfg
      $error("compare_seq: WIDTH must be a positive multiple of CHUNK");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_r;
  logic [WIDTH-1:0]   a_r;
  logic [WIDTH-1:0]   b_r;
  logic [CHUNK-1:0]   a_cmp_s;
  logic [CHUNK-1:0]   b_cmp_s;
  logic               last_s;

  // Operands shift left each RUN cycle, so the chunk under test is always the top CHUNK bits.
  always_comb begin
    a_cmp_s = a_r[WIDTH-1 -: CHUNK];
    b_cmp_s = b_r[WIDTH-1 -: CHUNK];
`ifdef SIGNED_EN
    if (cycles == CW'(0)) begin
      a_cmp_s[CHUNK-1] = ~a_r[WIDTH-1];
      b_cmp_s[CHUNK-1] = ~b_r[WIDTH-1];
    end else begin
      a_cmp_s[CHUNK-1] = a_r[WIDTH-1];
      b_cmp_s[CHUNK-1] = b_r[WIDTH-1];
    end
`endif
    last_s = (cycles == CW'(NCHUNK - 1));
  end

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_IDLE;
      a_r     <= '0;
      b_r     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      more    <= 1'b0;
      less    <= 1'b0;
      equal   <= 1'b0;
      cycles  <= '0;
    end else begin
      case (state_r)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_r     <= a;
            b_r     <= b;
            more    <= 1'b0;
            less    <= 1'b0;
            equal   <= 1'b0;
            cycles  <= '0;
            busy    <= 1'b1;
            state_r <= S_RUN;
          end else begin
            busy <= 1'b0;
          end
        end
        S_RUN: begin
          cycles <= cycles + CW'(1);
          a_r    <= a_r << CHUNK;
          b_r    <= b_r << CHUNK;
          if (a_cmp_s > b_cmp_s) begin
            more    <= 1'b1;
            done    <= 1'b1;
            state_r <= S_DONE;
          end else if (a_cmp_s < b_cmp_s) begin
            less    <= 1'b1;
            done    <= 1'b1;
            state_r <= S_DONE;
          end else if (last_s) begin
            equal   <= 1'b1;
            done    <= 1'b1;
            state_r <= S_DONE;
          end else begin
            state_r <= S_RUN;
          end
        end
        S_DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_r <= S_IDLE;
        end
        default: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_r <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_compare_seq.sv
// Self-checking bench for compare_seq (WIDTH=8, CHUNK=2): vector table plus hand-written
// sequences for reset, held start and mid-operation reset. Honours SIGNED_EN when defined.
module tb_compare_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       busy;
  logic       done;
  logic       more;
  logic       less;
  logic       equal;
  logic [2:0] cycles;

  // result codes: 0 equal, 1 more, 2 less
  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [1:0] ru;
    logic [1:0] rs;
    logic [2:0] cyc;
  } vec_t;

  typedef struct {
    logic       more;
    logic       less;
    logic       equal;
    logic [2:0] cyc;
  } exp_t;

  exp_t sbq[$];
  vec_t tbl[11];
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  compare_seq #(.WIDTH(8), .CHUNK(2)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .more   (more),
    .less   (less),
    .equal  (equal),
    .cycles (cycles)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk_exp(input logic [1:0] ru, input logic [1:0] rs, input logic [2:0] c);
    exp_t e;
    logic [1:0] r;
`ifdef SIGNED_EN
    r = rs;
`else
    r = ru;
`endif
    e.more  = (r == 2'd1);
    e.less  = (r == 2'd2);
    e.equal = (r == 2'd0);
    e.cyc   = c;
    return e;
  endfunction

  function automatic vec_t mk_vec(input logic [7:0] va, input logic [7:0] vb,
                                  input logic [1:0] ru, input logic [1:0] rs, input logic [2:0] c);
    vec_t v;
    v.a = va; v.b = vb; v.ru = ru; v.rs = rs; v.cyc = c;
    return v;
  endfunction

  // Called at a negedge: present a request and record what must come back.
  task automatic drive(input logic [7:0] va, input logic [7:0] vb, input exp_t e);
    a     = va;
    b     = vb;
    start = 1'b1;
    sbq.push_back(e);
  endtask

  // Counts negedges after the accepting posedge until done; checks latency, result, pulse width.
  task automatic wait_done(input bit hold, input int lat, input string tag);
    int   n    = 0;
    bit   seen = 1'b0;
    exp_t e;
    while (!seen && n < 20) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        if (hold) begin
          a = 8'h00;
          b = 8'hFF;
        end else begin
          start = 1'b0;
          a     = 8'($urandom);
          b     = 8'($urandom);
        end
      end
      if (done === 1'b1) seen = 1'b1;
    end
    check({tag, " done_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      check({tag, " latency"}, 32'(n), 32'(lat));
      if (sbq.size() == 0) begin
        check({tag, " scoreboard_nonempty"}, 32'd0, 32'd1);
      end else begin
        e = sbq.pop_front();
        check({tag, " more"},   32'(more),   32'(e.more));
        check({tag, " less"},   32'(less),   32'(e.less));
        check({tag, " equal"},  32'(equal),  32'(e.equal));
        check({tag, " cycles"}, 32'(cycles), 32'(e.cyc));
      end
      @(negedge clk);
      check({tag, " done_one_cycle"}, 32'(done), 32'd0);
      check({tag, " busy_cleared"},   32'(busy), 32'd0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int dones;
    rst   = 1'b1;
    start = 1'b1;
    a     = 8'h5A;
    b     = 8'h3C;

    tbl[0]  = mk_vec(8'h80, 8'h7F, 2'd1, 2'd2, 3'd1);
    tbl[1]  = mk_vec(8'h5A, 8'h5A, 2'd0, 2'd0, 3'd4);
    tbl[2]  = mk_vec(8'h13, 8'h12, 2'd1, 2'd1, 3'd4);
    tbl[3]  = mk_vec(8'h12, 8'h13, 2'd2, 2'd2, 3'd4);
    tbl[4]  = mk_vec(8'h00, 8'h00, 2'd0, 2'd0, 3'd4);
    tbl[5]  = mk_vec(8'hFF, 8'h00, 2'd1, 2'd2, 3'd1);
    tbl[6]  = mk_vec(8'h34, 8'h38, 2'd2, 2'd2, 3'd3);
    tbl[7]  = mk_vec(8'hC4, 8'hC0, 2'd1, 2'd1, 3'd3);
    tbl[8]  = mk_vec(8'h40, 8'h20, 2'd1, 2'd1, 3'd1);
    tbl[9]  = mk_vec(8'hFE, 8'hFF, 2'd2, 2'd2, 3'd4);
    tbl[10] = mk_vec(8'h7F, 8'h80, 2'd2, 2'd1, 3'd1);

    // Reset held two cycles with start asserted.
    repeat (2) @(negedge clk);
    check("rst busy",   32'(busy),   32'd0);
    check("rst done",   32'(done),   32'd0);
    check("rst more",   32'(more),   32'd0);
    check("rst less",   32'(less),   32'd0);
    check("rst equal",  32'(equal),  32'd0);
    check("rst cycles", 32'(cycles), 32'd0);
    rst   = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check("idle after rst busy", 32'(busy), 32'd0);

    for (int i = 0; i < 11; i++) begin
      drive(tbl[i].a, tbl[i].b, mk_exp(tbl[i].ru, tbl[i].rs, tbl[i].cyc));
      wait_done(1'b0, int'(tbl[i].cyc) + 1, $sformatf("vec%0d", i));
      @(negedge clk);
    end

    // Results stay put after done until the next accepted start.
    drive(8'h5A, 8'h5A, mk_exp(2'd0, 2'd0, 3'd4));
    wait_done(1'b0, 5, "hold_res");
    repeat (3) @(negedge clk);
    check("hold_res equal",  32'(equal),  32'd1);
    check("hold_res more",   32'(more),   32'd0);
    check("hold_res cycles", 32'(cycles), 32'd4);

    // start held high through RUN/DONE with new operands: ignored until back in IDLE.
    drive(8'h13, 8'h12, mk_exp(2'd1, 2'd1, 3'd4));
    wait_done(1'b1, 5, "held_start");
    drive(8'h00, 8'hFF, mk_exp(2'd2, 2'd1, 3'd1));
    wait_done(1'b0, 2, "reaccept");
    @(negedge clk);

    // Reset during the second RUN cycle aborts without a done pulse.
    a     = 8'h10;
    b     = 8'h11;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("abort busy in run", 32'(busy), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort busy",   32'(busy),   32'd0);
    check("abort done",   32'(done),   32'd0);
    check("abort less",   32'(less),   32'd0);
    check("abort cycles", 32'(cycles), 32'd0);
    dones = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
    end
    check("abort no done", 32'(dones), 32'd0);

    drive(8'h10, 8'h11, mk_exp(2'd2, 2'd2, 3'd4));
    wait_done(1'b0, 5, "after_abort");

    check("scoreboard drained", 32'(sbq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
